udp_port_dispatch: RTL and testbench
====================================

// Module: udp_port_dispatch
// PURPOSE
//  Sits above the UDP receive layer. Demultiplexes its payload stream to one of NUM_CH listener channels by destination port.
//  Holds a software-configured port table and drops packets for unknown or disabled ports.
//  Grades the UDP checksum at end of packet and keeps saturating delivered/dropped packet counters.
// PARAMETERS
//  NUM_CH   4   number of listener channels / port-table entries (1..16)
//  CH_AW    2   table address width, 2**CH_AW >= NUM_CH
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  cfg_wr       in   1        port-table write strobe
//  cfg_addr     in   CH_AW    table entry to write (>= NUM_CH: ignored)
//  cfg_port     in   16       UDP port for entry
//  cfg_en       in   1        entry enable
//  rx_dest_port in   16       destination port of current packet (stable from rx_op_st to rx_op_end)
//  rx_op_st     in   1        first payload word strobe
//  rx_op        in   1        payload word valid
//  rx_op_end    in   1        last payload word strobe
//  rx_data      in   32       payload word
//  rx_crc_sum   in   16       folded ones-complement sum; valid in the rx_op_end cycle
//  rx_checksum  in   16       checksum field from the UDP header
//  ch_op_st     out  NUM_CH   per-channel start strobe
//  ch_op        out  NUM_CH   per-channel word valid
//  ch_op_end    out  NUM_CH   per-channel end strobe
//  ch_data      out  32       shared payload bus; 0 when no ch_op bit is set
//  ch_stat_vld  out  1        one-cycle packet status strobe, coincident with ch_op_end
//  ch_stat_ok   out  1        1 = checksum good; valid with ch_stat_vld
//  pkt_cnt      out  16       packets delivered, saturates at 16'hFFFF
//  drop_cnt     out  16       packets dropped or aborted, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, table entries port=0 en=0, FSM=IDLE.
//  FSM states: IDLE, STREAM, DROP.
//  - IDLE, rx_op&rx_op_st: match rx_dest_port against enabled entries in the same cycle.
//    - Multiple hits: lowest index wins.
//    - Hit: latch channel index -> STREAM.
//    - Miss: -> DROP, increment drop_cnt.
//  - STREAM: each rx_op word is forwarded on the latched channel.
//    - Latency is exactly 1 cycle: ch_op/ch_data/ch_op_st/ch_op_end are registers of rx_op/rx_data/rx_op_st/rx_op_end.
//  - STREAM, rx_op&rx_op_end:
//    - Next cycle: ch_op_end, ch_stat_vld=1, ch_stat_ok=(rx_checksum==0)|(rx_crc_sum==16'hFFFF).
//    - Increment pkt_cnt (even if checksum bad); -> IDLE.
//  - DROP: swallow words, no outputs; on rx_op_end -> IDLE.
//  - Single-word packet (st and end same cycle): ch_op_st, ch_op and ch_op_end all 1 in the same output cycle; FSM stays IDLE.
//    - Miss case: drop counted, no outputs.
//  - rx_op_st while in STREAM (lost end):
//    - Next cycle: ch_op_end=1 on the old channel with ch_op=0, ch_data=0, ch_stat_vld=1, ch_stat_ok=0.
//    - drop_cnt+1; the new packet is dropped (drop_cnt+1 more, so +2 total) -> DROP.
//    - If the new packet's rx_op_end is in the same cycle -> IDLE.
//  - rx_op_st while in DROP: re-evaluate as from IDLE.
//  - rx_op_end without rx_op: treated as end with no word; status still generated in STREAM.
//  - Table writes take effect the cycle after cfg_wr.
//    - Routing is latched at start, so writes mid-packet never redirect or cut the active packet.
//  - Counters: 16-bit, saturate, never wrap; both may increment in the same cycle.
//  - Reset mid-packet: outputs drop to 0 immediately, no end strobe emitted; table cleared.
// TESTING
//  - Entry0=port 5000 en; 3-word packet to 5000 (A,B,C)
//    -> ch_op[0] 3 cycles, delayed 1 cycle, data A,B,C; st on A, end on C; stat_ok=1; pkt_cnt=1.
//  - Packet to port 6000 (no entry) -> no ch_* activity; drop_cnt=1; FSM back to IDLE after end.
//  - Entries 1 and 3 both port 80 en; packet to 80 -> routed to ch1 only.
//  - rx_checksum=16'h1234, rx_crc_sum=16'hFFFE at end -> ch_stat_vld=1, ch_stat_ok=0, pkt_cnt still increments.
//  - Second rx_op_st mid-packet on ch0 -> ch_op_end[0]=1 with stat_ok=0, drop_cnt+2, second packet not forwarded.
//  - Single-word packet; cfg_wr disabling the active entry mid-packet; rst_n low mid-stream
//    -> correct strobes, no redirect, all outputs 0 after reset.

Source files
------------

// File: rtl/udp_port_dispatch.sv
// UDP destination-port dispatcher: routes receive payload words to one of NUM_CH
// listener channels via a software port table, grades checksums, counts packets.
module udp_port_dispatch #(
  parameter int NUM_CH = 4,
  parameter int CH_AW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CH_AW-1:0]  cfg_addr,
  input  logic [15:0]       cfg_port,
  input  logic              cfg_en,
  input  logic [15:0]       rx_dest_port,
  input  logic              rx_op_st,
  input  logic              rx_op,
  input  logic              rx_op_end,
  input  logic [31:0]       rx_data,
  input  logic [15:0]       rx_crc_sum,
  input  logic [15:0]       rx_checksum,
  output logic [NUM_CH-1:0] ch_op_st,
  output logic [NUM_CH-1:0] ch_op,
  output logic [NUM_CH-1:0] ch_op_end,
  output logic [31:0]       ch_data,
  output logic              ch_stat_vld,
  output logic              ch_stat_ok,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DROP
  } state_t;

  state_t state, nxt_state;

  logic [15:0]       port_tbl [NUM_CH];
  logic [NUM_CH-1:0] en_tbl;

  logic [CH_AW-1:0]  chan, nxt_chan;
  logic              hit;
  logic [CH_AW-1:0]  hit_idx;

  logic              start;
  logic              csum_good;

  logic              nxt_st, nxt_op, nxt_end, nxt_vld, nxt_ok;
  logic [31:0]       nxt_data;
  logic [CH_AW-1:0]  tgt;
  logic [NUM_CH-1:0] tgt_oh;

  logic              pkt_inc;
  logic [1:0]        drop_inc;
  logic [16:0]       pkt_sum, drop_sum;

  // Addresses beyond NUM_CH simply match no entry, so such writes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) port_tbl[i] <= '0;
      en_tbl <= '0;
    end else if (cfg_wr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_addr == CH_AW'(i)) begin
          port_tbl[i] <= cfg_port;
          en_tbl[i]   <= cfg_en;
        end
      end
    end
  end

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en_tbl[i] && (port_tbl[i] == rx_dest_port)) begin
        hit     = 1'b1;
        hit_idx = CH_AW'(i);
      end
    end
  end

  assign start     = rx_op & rx_op_st;
  assign csum_good = (rx_checksum == 16'h0000) | (rx_crc_sum == 16'hFFFF);

  always_comb begin
    nxt_state = state;
    nxt_chan  = chan;
    nxt_st    = 1'b0;
    nxt_op    = 1'b0;
    nxt_end   = 1'b0;
    nxt_data  = '0;
    nxt_vld   = 1'b0;
    nxt_ok    = 1'b0;
    tgt       = chan;
    pkt_inc   = 1'b0;
    drop_inc  = 2'd0;

    case (state)
      IDLE, DROP: begin
        if (start) begin
          if (hit) begin
            nxt_chan = hit_idx;
            tgt      = hit_idx;
            nxt_st   = 1'b1;
            nxt_op   = 1'b1;
            nxt_data = rx_data;
            if (rx_op_end) begin
              nxt_end   = 1'b1;
              nxt_vld   = 1'b1;
              nxt_ok    = csum_good;
              pkt_inc   = 1'b1;
              nxt_state = IDLE;
            end else begin
              nxt_state = STREAM;
            end
          end else begin
            drop_inc  = 2'd1;
            nxt_state = rx_op_end ? IDLE : DROP;
          end
        end else if (state == DROP && rx_op_end) begin
          nxt_state = IDLE;
        end
      end

      STREAM: begin
        if (start) begin
          // A new start before the old end: close the old packet as bad and drop the new one.
          nxt_end   = 1'b1;
          nxt_vld   = 1'b1;
          nxt_ok    = 1'b0;
          drop_inc  = 2'd2;
          nxt_state = rx_op_end ? IDLE : DROP;
        end else begin
          if (rx_op) begin
            nxt_op   = 1'b1;
            nxt_data = rx_data;
          end
          if (rx_op_end) begin
            nxt_end   = 1'b1;
            nxt_vld   = 1'b1;
            nxt_ok    = csum_good;
            pkt_inc   = 1'b1;
            nxt_state = IDLE;
          end
        end
      end

      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    tgt_oh = '0;
    for (int i = 0; i < NUM_CH; i++) tgt_oh[i] = (tgt == CH_AW'(i));
  end

  assign pkt_sum  = {1'b0, pkt_cnt} + {16'b0, pkt_inc};
  assign drop_sum = {1'b0, drop_cnt} + {15'b0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      chan  <= '0;
    end else begin
      state <= nxt_state;
      chan  <= nxt_chan;
    end
  end

  // Every channel output is a flop, so forwarding latency is exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_op_st    <= '0;
      ch_op       <= '0;
      ch_op_end   <= '0;
      ch_data     <= '0;
      ch_stat_vld <= 1'b0;
      ch_stat_ok  <= 1'b0;
      pkt_cnt     <= '0;
      drop_cnt    <= '0;
    end else begin
      ch_op_st    <= nxt_st  ? tgt_oh : '0;
      ch_op       <= nxt_op  ? tgt_oh : '0;
      ch_op_end   <= nxt_end ? tgt_oh : '0;
      ch_data     <= nxt_data;
      ch_stat_vld <= nxt_vld;
      ch_stat_ok  <= nxt_ok;
      pkt_cnt     <= pkt_sum[16]  ? 16'hFFFF : pkt_sum[15:0];
      drop_cnt    <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_udp_port_dispatch.sv
// Directed bench for udp_port_dispatch: routing, drops, checksum grading,
// lost-end recovery, single-word packets, mid-packet table writes and reset.
module tb_udp_port_dispatch;

  logic        clk;
  logic        rst_n;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_port;
  logic        cfg_en;
  logic [15:0] rx_dest_port;
  logic        rx_op_st, rx_op, rx_op_end;
  logic [31:0] rx_data;
  logic [15:0] rx_crc_sum, rx_checksum;
  logic [3:0]  ch_op_st, ch_op, ch_op_end;
  logic [31:0] ch_data;
  logic        ch_stat_vld, ch_stat_ok;
  logic [15:0] pkt_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;

  udp_port_dispatch #(.NUM_CH(4), .CH_AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_port(cfg_port), .cfg_en(cfg_en),
    .rx_dest_port(rx_dest_port), .rx_op_st(rx_op_st), .rx_op(rx_op),
    .rx_op_end(rx_op_end), .rx_data(rx_data), .rx_crc_sum(rx_crc_sum),
    .rx_checksum(rx_checksum),
    .ch_op_st(ch_op_st), .ch_op(ch_op), .ch_op_end(ch_op_end), .ch_data(ch_data),
    .ch_stat_vld(ch_stat_vld), .ch_stat_ok(ch_stat_ok),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven 1 time unit after a rising edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic op, input logic en_d, input logic [31:0] d);
    rx_op_st  = st;
    rx_op     = op;
    rx_op_end = en_d;
    rx_data   = d;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] p, input logic e);
    cfg_wr = 1'b1; cfg_addr = a; cfg_port = p; cfg_en = e;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if ({ch_op_st, ch_op, ch_op_end, ch_stat_vld, ch_stat_ok} !== 14'h0) begin errors++; $display("[TB] FAIL reset_strobes got=%h exp=0", {ch_op_st, ch_op, ch_op_end, ch_stat_vld, ch_stat_ok}); end
    checks++; if (ch_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", ch_data); end
    checks++; if ({pkt_cnt, drop_cnt} !== 32'h0) begin errors++; $display("[TB] FAIL reset_counters got=%h exp=0", {pkt_cnt, drop_cnt}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] w [3];
    w = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    rx_dest_port = 16'd5000; rx_checksum = 16'h0; rx_crc_sum = 16'h0;
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1'b1, i == 2, w[i]);
      if (i == 0) begin
        checks++; if (ch_op !== 4'b0000) begin errors++; $display("[TB] FAIL basic_latency got=%b exp=0000", ch_op); end
      end
      step();
      checks++; if (ch_op !== 4'b0001) begin errors++; $display("[TB] FAIL basic_op%0d got=%b exp=0001", i, ch_op); end
      checks++; if (ch_data !== w[i]) begin errors++; $display("[TB] FAIL basic_data%0d got=%h exp=%h", i, ch_data, w[i]); end
      checks++; if (ch_op_st !== ((i == 0) ? 4'b0001 : 4'b0000)) begin errors++; $display("[TB] FAIL basic_st%0d got=%b", i, ch_op_st); end
      checks++; if (ch_op_end !== ((i == 2) ? 4'b0001 : 4'b0000)) begin errors++; $display("[TB] FAIL basic_end%0d got=%b", i, ch_op_end); end
      checks++; if (ch_stat_vld !== (i == 2)) begin errors++; $display("[TB] FAIL basic_vld%0d got=%b", i, ch_stat_vld); end
    end
    checks++; if (ch_stat_ok !== 1'b1) begin errors++; $display("[TB] FAIL basic_ok got=%b exp=1", ch_stat_ok); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("[TB] FAIL basic_pkt got=%0d exp=1", pkt_cnt); end
    drive(0, 0, 0, 32'h0);
    step();
    checks++; if ({ch_op, ch_op_end, ch_stat_vld} !== 9'h0) begin errors++; $display("[TB] FAIL basic_idle got=%h exp=0", {ch_op, ch_op_end, ch_stat_vld}); end
    checks++; if (ch_data !== 32'h0) begin errors++; $display("[TB] FAIL basic_idle_data got=%h exp=0", ch_data); end
  endtask

  task automatic test_drop();
    rx_dest_port = 16'd6000;
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1'b1, i == 2, 32'h6000_0000 + 32'(i));
      step();
      checks++; if ({ch_op_st, ch_op, ch_op_end, ch_stat_vld} !== 13'h0) begin errors++; $display("[TB] FAIL drop_quiet%0d got=%h exp=0", i, {ch_op_st, ch_op, ch_op_end, ch_stat_vld}); end
      checks++; if (drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_cnt%0d got=%0d exp=1", i, drop_cnt); end
    end
    drive(0, 0, 0, 32'h0);
    step();
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_pkt got=%0d exp=1", pkt_cnt); end
  endtask

  task automatic test_priority();
    rx_dest_port = 16'd80; rx_checksum = 16'h0;
    drive(1, 1, 0, 32'h8000_0001);
    step();
    checks++; if (ch_op_st !== 4'b0010) begin errors++; $display("[TB] FAIL prio_st got=%b exp=0010", ch_op_st); end
    drive(0, 1, 1, 32'h8000_0002);
    step();
    checks++; if (ch_op_end !== 4'b0010) begin errors++; $display("[TB] FAIL prio_end got=%b exp=0010", ch_op_end); end
    checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("[TB] FAIL prio_pkt got=%0d exp=2", pkt_cnt); end
    drive(0, 0, 0, 32'h0);
    cfg_write(2'd1, 16'd80, 1'b0);
    drive(1, 1, 0, 32'h8000_0003);
    step();
    checks++; if (ch_op !== 4'b1000) begin errors++; $display("[TB] FAIL prio_disabled_op got=%b exp=1000", ch_op); end
    drive(0, 1, 1, 32'h8000_0004);
    step();
    checks++; if (ch_op_end !== 4'b1000) begin errors++; $display("[TB] FAIL prio_disabled_end got=%b exp=1000", ch_op_end); end
    checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("[TB] FAIL prio_pkt2 got=%0d exp=3", pkt_cnt); end
    drive(0, 0, 0, 32'h0);
    step();
  endtask

  task automatic test_bad_checksum();
    rx_dest_port = 16'd5000; rx_checksum = 16'h1234; rx_crc_sum = 16'hFFFE;
    drive(1, 1, 0, 32'h1111_0001);
    step();
    checks++; if (ch_op !== 4'b0001) begin errors++; $display("[TB] FAIL badck_op got=%b exp=0001", ch_op); end
    drive(0, 1, 1, 32'h1111_0002);
    step();
    checks++; if (ch_stat_vld !== 1'b1 || ch_stat_ok !== 1'b0) begin errors++; $display("[TB] FAIL badck_stat got=%b%b exp=10", ch_stat_vld, ch_stat_ok); end
    checks++; if (pkt_cnt !== 16'd4) begin errors++; $display("[TB] FAIL badck_pkt got=%0d exp=4", pkt_cnt); end
    drive(0, 0, 0, 32'h0);
    rx_checksum = 16'h0; rx_crc_sum = 16'h0;
    step();
  endtask

  task automatic test_lost_end();
    rx_dest_port = 16'd5000;
    drive(1, 1, 0, 32'h2222_0001);
    step();
    checks++; if (ch_op !== 4'b0001) begin errors++; $display("[TB] FAIL lost_first got=%b exp=0001", ch_op); end
    drive(1, 1, 0, 32'h2222_0002);
    step();
    checks++; if (ch_op_end !== 4'b0001) begin errors++; $display("[TB] FAIL lost_end got=%b exp=0001", ch_op_end); end
    checks++; if ({ch_op_st, ch_op} !== 8'h0 || ch_data !== 32'h0) begin errors++; $display("[TB] FAIL lost_word got=%h/%h exp=0/0", {ch_op_st, ch_op}, ch_data); end
    checks++; if (ch_stat_vld !== 1'b1 || ch_stat_ok !== 1'b0) begin errors++; $display("[TB] FAIL lost_stat got=%b%b exp=10", ch_stat_vld, ch_stat_ok); end
    checks++; if (drop_cnt !== 16'd3) begin errors++; $display("[TB] FAIL lost_drop got=%0d exp=3", drop_cnt); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, i == 1, 32'h2222_0003 + 32'(i));
      step();
      checks++; if ({ch_op_st, ch_op, ch_op_end, ch_stat_vld} !== 13'h0) begin errors++; $display("[TB] FAIL lost_swallow%0d got=%h exp=0", i, {ch_op_st, ch_op, ch_op_end, ch_stat_vld}); end
    end
    drive(0, 0, 0, 32'h0);
    step();
    checks++; if (pkt_cnt !== 16'd4 || drop_cnt !== 16'd3) begin errors++; $display("[TB] FAIL lost_counts got=%0d/%0d exp=4/3", pkt_cnt, drop_cnt); end
  endtask

  task automatic test_single_word();
    rx_dest_port = 16'd5000; rx_checksum = 16'h5555; rx_crc_sum = 16'hFFFF;
    drive(1, 1, 1, 32'h3333_0001);
    step();
    checks++; if ({ch_op_st, ch_op, ch_op_end} !== 12'h111) begin errors++; $display("[TB] FAIL single_strobes got=%h exp=111", {ch_op_st, ch_op, ch_op_end}); end
    checks++; if (ch_data !== 32'h3333_0001) begin errors++; $display("[TB] FAIL single_data got=%h exp=33330001", ch_data); end
    checks++; if (ch_stat_vld !== 1'b1 || ch_stat_ok !== 1'b1) begin errors++; $display("[TB] FAIL single_stat got=%b%b exp=11", ch_stat_vld, ch_stat_ok); end
    checks++; if (pkt_cnt !== 16'd5) begin errors++; $display("[TB] FAIL single_pkt got=%0d exp=5", pkt_cnt); end
    rx_dest_port = 16'd7;
    drive(1, 1, 1, 32'h3333_0002);
    step();
    checks++; if ({ch_op_st, ch_op, ch_op_end, ch_stat_vld} !== 13'h0) begin errors++; $display("[TB] FAIL single_miss got=%h exp=0", {ch_op_st, ch_op, ch_op_end, ch_stat_vld}); end
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("[TB] FAIL single_miss_drop got=%0d exp=4", drop_cnt); end
    test_back_to_back();
  endtask

  task automatic test_back_to_back();
    rx_dest_port = 16'd5000; rx_checksum = 16'h0; rx_crc_sum = 16'h0;
    drive(1, 1, 1, 32'h4444_0001);
    step();
    checks++; if ({ch_op_st, ch_op, ch_op_end} !== 12'h111) begin errors++; $display("[TB] FAIL b2b_strobes got=%h exp=111", {ch_op_st, ch_op, ch_op_end}); end
    checks++; if (pkt_cnt !== 16'd6) begin errors++; $display("[TB] FAIL b2b_pkt got=%0d exp=6", pkt_cnt); end
    drive(0, 0, 0, 32'h0);
    step();
    checks++; if ({ch_op_st, ch_op, ch_op_end, ch_stat_vld} !== 13'h0) begin errors++; $display("[TB] FAIL b2b_idle got=%h exp=0", {ch_op_st, ch_op, ch_op_end, ch_stat_vld}); end
  endtask

  task automatic test_cfg_mid();
    rx_dest_port = 16'd5000;
    drive(1, 1, 0, 32'h5555_0001);
    step();
    drive(0, 1, 0, 32'h5555_0002);
    cfg_write(2'd0, 16'd5000, 1'b0);
    checks++; if (ch_op !== 4'b0001 || ch_data !== 32'h5555_0002) begin errors++; $display("[TB] FAIL cfgmid_word got=%b/%h exp=0001/55550002", ch_op, ch_data); end
    drive(0, 1, 1, 32'h5555_0003);
    step();
    checks++; if (ch_op_end !== 4'b0001 || ch_stat_ok !== 1'b1) begin errors++; $display("[TB] FAIL cfgmid_end got=%b/%b exp=0001/1", ch_op_end, ch_stat_ok); end
    checks++; if (pkt_cnt !== 16'd7) begin errors++; $display("[TB] FAIL cfgmid_pkt got=%0d exp=7", pkt_cnt); end
    drive(1, 1, 1, 32'h5555_0004);
    step();
    checks++; if ({ch_op_st, ch_op, ch_op_end, ch_stat_vld} !== 13'h0) begin errors++; $display("[TB] FAIL cfgmid_after got=%h exp=0", {ch_op_st, ch_op, ch_op_end, ch_stat_vld}); end
    checks++; if (drop_cnt !== 16'd5) begin errors++; $display("[TB] FAIL cfgmid_drop got=%0d exp=5", drop_cnt); end
    drive(0, 0, 0, 32'h0);
    step();
  endtask

  task automatic test_reset_mid();
    rx_dest_port = 16'd80;
    drive(1, 1, 0, 32'h6666_0001);
    step();
    checks++; if (ch_op !== 4'b1000) begin errors++; $display("[TB] FAIL rstmid_pre got=%b exp=1000", ch_op); end
    drive(0, 1, 0, 32'h6666_0002);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ch_op_st, ch_op, ch_op_end, ch_stat_vld, ch_stat_ok} !== 14'h0) begin errors++; $display("[TB] FAIL rstmid_outs got=%h exp=0", {ch_op_st, ch_op, ch_op_end, ch_stat_vld, ch_stat_ok}); end
    checks++; if (ch_data !== 32'h0 || pkt_cnt !== 16'h0 || drop_cnt !== 16'h0) begin errors++; $display("[TB] FAIL rstmid_regs got=%h/%0d/%0d exp=0/0/0", ch_data, pkt_cnt, drop_cnt); end
    drive(0, 0, 0, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    drive(1, 1, 1, 32'h6666_0003);
    step();
    checks++; if ({ch_op_st, ch_op, ch_op_end, ch_stat_vld} !== 13'h0) begin errors++; $display("[TB] FAIL rstmid_table got=%h exp=0", {ch_op_st, ch_op, ch_op_end, ch_stat_vld}); end
    checks++; if (drop_cnt !== 16'd1 || pkt_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_counts got=%0d/%0d exp=1/0", drop_cnt, pkt_cnt); end
    drive(0, 0, 0, 32'h0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_port = '0; cfg_en = 1'b0;
    rx_dest_port = '0; rx_crc_sum = '0; rx_checksum = '0;
    drive(0, 0, 0, 32'h0);
    test_reset();
    cfg_write(2'd0, 16'd5000, 1'b1);
    cfg_write(2'd1, 16'd80, 1'b1);
    cfg_write(2'd3, 16'd80, 1'b1);
    test_basic();
    test_drop();
    test_priority();
    test_bad_checksum();
    test_lost_end();
    test_single_word();
    test_cfg_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
